ahb_lite_sram_slave: RTL
========================

Name: ahb_lite_sram_slave

Overview:
Synthesisable, parametrised AHB-Lite slave that fronts an internal word-organised SRAM array. It is the DUT-side counterpart of the dut_if bus bundle and uses the same AW/DW/DE/RW parameter set and signal names. It adds programmable wait states, byte/halfword lane writes, and a two-cycle ERROR response for illegal transfers. It sits behind the AHB decoder/mux and is the first real slave targeted by the existing driver/monitor bench.

Parameters:
AW, 32, address bus width
DW, 32, data bus width (32 or 64)
DE, 0, endianness (0 = little, 1 = big; selects byte-lane mapping)
RW, 1, hresp width (AHB-Lite uses 1)
DEPTH, 1024, number of DW-bit words in the array
WAIT, 0, wait states inserted per OKAY data phase (0..15)

Ports:
hclk  input  1  bus clock
hresetn  input  1  asynchronous active-low reset
hsel  input  1  slave select from decoder
haddr  input  AW  transfer address
htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  input  1  1 = write
hsize  input  3  transfer size (byte, half, word, dword)
hburst  input  3  burst type (informational only; addresses come from the master)
hprot  input  4  protection (ignored)
hwdata  input  DW  write data
hready  input  1  bus-wide ready (previous data phase complete)
hreadyout  output  DW→1  slave ready
hrdata  output  DW  read data
hresp  output  RW  0 = OKAY, 1 = ERROR

Behaviour:
- Reset: one clock (hclk); reset is asynchronous, active-low (hresetn). Asserting hresetn low forces:
  - hreadyout = 1, hresp = 0, hrdata = 0;
  - FSM to IDLE, wait counter to 0, all captured address-phase registers cleared.
  - Array contents are not reset.
- Reset mid-transfer: the transfer is aborted and no array write occurs.
- Address-phase accept: a transfer is accepted on a rising edge where hsel & hready & htrans[1]. On accept, haddr, hwrite and hsize are registered.
- IDLE/BUSY handling: an IDLE or BUSY transfer, or hsel = 0, gets a zero-wait OKAY response.
- Illegal transfer, detected at accept, is any of:
  - byte address >= DEPTH*DW/8;
  - hsize > log2(DW/8);
  - address not aligned to hsize.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE: legal accept → DATA with counter = WAIT. Illegal accept → ERR1.
  - DATA: hreadyout = (counter == 0), hresp = 0. Counter decrements each cycle while nonzero. In the cycle with hreadyout = 1, the transfer completes and a new accept is evaluated in that same cycle (pipelined): legal → DATA, illegal → ERR1, none → IDLE.
  - ERR1: hreadyout = 0, hresp = 1. Always → ERR2. Address phases are ignored because hready is low.
  - ERR2: hreadyout = 1, hresp = 1. The next accept is evaluated as in IDLE.
- WAIT = 0: back-to-back NONSEQ/SEQ transfers run at one transfer per cycle.
- Write: hwdata is sampled in the completing DATA cycle (hreadyout = 1) and written at that clock edge.
  - Only the byte lanes selected by hsize and the low address bits are written.
  - DE = 1 mirrors the lane index within the word.
  - ERROR transfers never write.
- Read: hrdata presents the addressed word, full DW with all lanes driven, in the completing DATA cycle.
  - The array is read using the registered address.
  - hrdata holds its last value outside completing read cycles.
  - On ERROR, hrdata is 0.
- Write-then-read of the same address in consecutive transfers returns the new data: the write commits at the end of its data phase, before the read data phase.
- Address wrap: word index = byte address / (DW/8). No wrap occurs inside the slave; out-of-range addresses are reported as ERROR.
- Simultaneous events: a new accept in the completing cycle of a prior transfer is handled as above. hsel deasserted mid-data-phase does not affect the in-flight transfer.

Test Plan:
- WAIT=0: NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ read @0x10 → hreadyout never low; hrdata = 0xDEADBEEF in the read data phase; hresp = 0.
- WAIT=2: single read @0x0 → hreadyout low for exactly 2 cycles, then high with valid data; a 4-beat INCR4 write burst takes 12 data cycles.
- Byte lanes (DE=0): write 0x11223344 @0x20, then byte write 0xAA @0x21 → read @0x20 returns 0x1122AA44. With DE=1 the same sequence returns 0x11AA3344.
- Error: write @ DEPTH*4 → hreadyout = 0/hresp = 1 for one cycle, then hreadyout = 1/hresp = 1; a following read of that word's alias @0x0 shows the array unchanged; a misaligned halfword @0x3 also gives ERROR.
- Idle/busy: htrans = IDLE, BUSY, or hsel = 0 with NONSEQ → hreadyout = 1, hresp = 0, no write.
- Reset: drop hresetn during a WAIT=3 write data phase → hreadyout = 1 and hresp = 0 immediately (asynchronous); a later read of the target address returns the old data.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
//
// AHB-Lite slave in front of a word-organised internal SRAM array. Each
// accepted transfer is checked for legality (range, size, alignment). Legal
// transfers get WAIT wait states followed by an OKAY data phase. Illegal
// transfers get the two-cycle ERROR response. Writes update only the byte
// lanes that hsize and the low address bits select. DE chooses little- or
// big-endian lane numbering.
//
// Ports:
//   hclk, hresetn   bus clock, asynchronous active-low reset
//   hsel            slave select from the decoder
//   haddr, htrans,
//   hwrite, hsize   address-phase control, registered on accept
//   hburst, hprot   accepted but not used (the master supplies every address)
//   hwdata          write data, sampled in the completing data cycle
//   hready          bus-wide ready (the previous data phase is complete)
//   hreadyout       this slave's ready
//   hrdata          read data, held between completing read cycles
//   hresp           0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DE    = 0,
    parameter int RW    = 1,
    parameter int DEPTH = 1024,
    parameter int WAIT  = 0
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [DW-1:0] hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic [DW-1:0] hrdata,
    output logic [RW-1:0] hresp
);

    localparam int NB = DW / 8;
    localparam int BW = $clog2(NB);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [DW-1:0] mem [DEPTH];

    logic          ready_int;
    logic          resp_int;
    logic          accept;
    logic          illegal;
    logic          out_of_range;
    logic          too_big;
    logic          misaligned;
    logic [BW-1:0] align_mask;
    logic [AW-1:0] word_idx;
    logic          complete;
    logic          mem_we;
    logic [NB-1:0] lane_we;
    logic [IW-1:0] idx_q;
    int            lane_lo;
    int            lane_n;

    // hburst/hprot are unused, and only the index bits of addr_q are needed.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot, htrans[0], addr_q};

    // -----------------------------------------------------------------------
    // Legality of the transfer currently presented in the address phase.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first. That way no
        // path can leave a signal unassigned and infer a latch.
        align_mask = '0;
        for (int i = 0; i < BW; i++) begin
            align_mask[i] = (i < int'(hsize));
        end
        word_idx     = haddr >> BW;
        out_of_range = (word_idx >= AW'(DEPTH));
        too_big      = (hsize > 3'(BW));
        misaligned   = |(haddr[BW-1:0] & align_mask);
        illegal      = out_of_range | too_big | misaligned;
    end

    // -----------------------------------------------------------------------
    // Response outputs come straight from the state. A reset therefore shows
    // on the bus at once, without waiting for a clock edge.
    // -----------------------------------------------------------------------
    always_comb begin
        ready_int = 1'b1;
        resp_int  = 1'b0;
        case (state_q)
            ST_DATA: ready_int = (cnt_q == '0);
            ST_ERR1: begin
                ready_int = 1'b0;
                resp_int  = 1'b1;
            end
            ST_ERR2: resp_int = 1'b1;
            default: ;
        endcase
    end

    // A new address phase can only be taken when this slave is ready. That is
    // IDLE, a completing DATA cycle, or ERR2.
    assign accept = hsel & hready & htrans[1] & ready_int;

    // -----------------------------------------------------------------------
    // Next-state logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;

        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (!ready_int) begin
            // Only a DATA phase with wait states left gets here.
            cnt_d = cnt_q - 4'd1;
        end else if (accept) begin
            addr_d  = haddr;
            write_d = hwrite;
            size_d  = hsize;
            if (illegal) begin
                state_d = ST_ERR1;
                cnt_d   = '0;
            end else begin
                state_d = ST_DATA;
                cnt_d   = 4'(WAIT);
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Data phase: byte-lane enables and the read mux.
    // -----------------------------------------------------------------------
    assign complete = (state_q == ST_DATA) && (cnt_q == '0);
    assign mem_we   = complete && write_q;
    assign idx_q    = addr_q[BW +: IW];

    always_comb begin
        lane_we = '0;
        lane_lo = int'(addr_q[BW-1:0]);
        lane_n  = 1 << int'(size_q);
        for (int i = 0; i < NB; i++) begin
            // Byte offset i within the word sits on lane i (little-endian)
            // or on lane NB-1-i (big-endian).
            if (i >= lane_lo && i < lane_lo + lane_n) begin
                lane_we[(DE != 0) ? (NB - 1 - i) : i] = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (complete && !write_q) begin
            rdata_d = mem[idx_q];
        end else if (state_q == ST_ERR1 || state_q == ST_ERR2) begin
            rdata_d = '0;
        end
    end

    assign hreadyout = ready_int;
    assign hresp     = RW'(resp_int);
    assign hrdata    = rdata_d;

    // -----------------------------------------------------------------------
    // Registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        // NOTE: sequential state uses non-blocking assignments. All flops
        // then update together from values sampled before the edge.
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array has no reset. Its contents survive hresetn. A transfer
    // cut short by reset cannot write, because mem_we depends on state_q,
    // and state_q is reset.
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_we[i]) begin
                    mem[idx_q][i*8 +: 8] <= hwdata[i*8 +: 8];
                end
            end
        end
    end

endmodule
